// File: rtl/bp_nbf_pkg.sv
// Shared NBF (network boot format) command definitions, used by the
// AXI-Lite deserializer and the NBF loader.
package bp_nbf_pkg;

    localparam int nbf_opcode_width_gp = 8;
    localparam int nbf_addr_width_gp   = 64;
    localparam int nbf_data_width_gp   = 64;
    localparam int nbf_flits_gp        = 5;
    localparam int nbf_flit_width_gp   = 32;

    localparam logic [nbf_opcode_width_gp-1:0] nbf_finish_opcode_gp = 8'hFF;

    typedef struct packed {
        logic [nbf_opcode_width_gp-1:0] opcode;
        logic [nbf_addr_width_gp-1:0]   addr;
        logic [nbf_data_width_gp-1:0]   data;
    } bp_nbf_s;

    typedef enum logic [1:0] {
        e_recv = 2'd0,
        e_resp = 2'd1,
        e_out  = 2'd2
    } nbf_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; a clear and an up in the same cycle
// leave the counter at init_val_p + 1.
module bsg_counter_clear_up #(
    parameter int max_val_p  = 5,
    parameter int init_val_p = 0,
    localparam int ptr_width_lp = $clog2(max_val_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    up_i,
    output logic [ptr_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] count_r;
    logic [ptr_width_lp-1:0] up_s;

    assign up_s = {{(ptr_width_lp-1){1'b0}}, up_i};

    // count register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= ptr_width_lp'(init_val_p);
        end else if (clear_i) begin
            count_r <= ptr_width_lp'(init_val_p) + up_s;
        end else begin
            count_r <= count_r + up_s;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/bp_axil_nbf_deserializer.sv
// AXI-Lite slave that assembles five 32-bit writes into one NBF command and
// hands it off on a valid/ready port; reads return the handed-off command count.
module bp_axil_nbf_deserializer
    import bp_nbf_pkg::*;
#(
    parameter int S_AXIL_ADDR_WIDTH = 64,
    parameter int S_AXIL_DATA_WIDTH = 32,
    parameter logic [S_AXIL_ADDR_WIDTH-1:0] nbf_host_addr_p = 64'h0
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    input  logic [2:0]                   s_axil_awprot,
    input  logic [S_AXIL_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    input  logic [3:0]                   s_axil_wstrb,
    output logic [1:0]                   s_axil_bresp,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    input  logic [2:0]                   s_axil_arprot,
    output logic [S_AXIL_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready,
    output bp_nbf_s                      nbf_o,
    output logic                         nbf_v_o,
    input  logic                         nbf_ready_and_i,
    output logic                         done_o
);

    nbf_state_e state_r, state_n;

    logic                         aw_held_r;
    logic [S_AXIL_ADDR_WIDTH-1:0] aw_addr_r;
    logic                         w_held_r;
    logic [S_AXIL_DATA_WIDTH-1:0] w_data_r;
    logic [nbf_flit_width_gp-1:0] flit_r [nbf_flits_gp];
    logic [2:0]                   flit_cnt_s;
    logic                         bvalid_r, last_flit_r, done_r, rvalid_r;
    logic [1:0]                   bresp_r;
    logic [31:0]                  cmd_count_r;
    logic [S_AXIL_DATA_WIDTH-1:0] rdata_r;

    logic aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, out_hs_s;
    logic commit_s, match_s, up_s, clear_s;
    logic [S_AXIL_ADDR_WIDTH-1:0] commit_addr_s;
    logic [S_AXIL_DATA_WIDTH-1:0] commit_data_s;
    logic unused_s;

    assign s_axil_awready = (state_r == e_recv) & ~aw_held_r & ~reset_i;
    assign s_axil_wready  = (state_r == e_recv) & ~w_held_r & ~reset_i;
    assign s_axil_arready = ~rvalid_r & ~reset_i;

    assign aw_hs_s  = s_axil_awvalid & s_axil_awready;
    assign w_hs_s   = s_axil_wvalid & s_axil_wready;
    assign ar_hs_s  = s_axil_arvalid & s_axil_arready;
    assign b_hs_s   = bvalid_r & s_axil_bready;
    assign out_hs_s = nbf_v_o & nbf_ready_and_i;

    // A held beat and a same-cycle handshake both count as available.
    assign commit_s      = (state_r == e_recv) & (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
    assign commit_addr_s = aw_held_r ? aw_addr_r : s_axil_awaddr;
    assign commit_data_s = w_held_r ? w_data_r : s_axil_wdata;
    assign match_s       = (commit_addr_s == nbf_host_addr_p);
    assign up_s          = commit_s & match_s;
    assign clear_s       = (state_r == e_resp) & b_hs_s & last_flit_r;

    bsg_counter_clear_up #(
        .max_val_p (nbf_flits_gp),
        .init_val_p(0)
    ) flit_counter (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(clear_s),
        .up_i   (up_s),
        .count_o(flit_cnt_s)
    );

    // state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_recv;
        else         state_r <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_recv:  if (commit_s) state_n = e_resp; else state_n = state_r;
            e_resp:  if (b_hs_s) state_n = last_flit_r ? e_out : e_recv; else state_n = state_r;
            e_out:   if (out_hs_s) state_n = e_recv; else state_n = state_r;
            default: state_n = e_recv;
        endcase
    end

    // AW/W one-entry holding registers, emptied by the commit
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            aw_held_r <= 1'b0;
            aw_addr_r <= '0;
            w_held_r  <= 1'b0;
            w_data_r  <= '0;
        end else begin
            aw_held_r <= commit_s ? 1'b0 : (aw_held_r | aw_hs_s);
            aw_addr_r <= aw_hs_s ? s_axil_awaddr : aw_addr_r;
            w_held_r  <= commit_s ? 1'b0 : (w_held_r | w_hs_s);
            w_data_r  <= w_hs_s ? s_axil_wdata : w_data_r;
        end
    end

    // flit storage, indexed by the flit counter
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < nbf_flits_gp; i++) flit_r[i] <= '0;
        end else begin
            for (int i = 0; i < nbf_flits_gp; i++) begin
                if (up_s && (flit_cnt_s == 3'(i))) flit_r[i] <= commit_data_s;
            end
        end
    end

    // write response channel
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bvalid_r    <= 1'b0;
            bresp_r     <= 2'b00;
            last_flit_r <= 1'b0;
        end else if (commit_s) begin
            bvalid_r    <= 1'b1;
            bresp_r     <= match_s ? 2'b00 : 2'b10;
            last_flit_r <= match_s & (flit_cnt_s == 3'(nbf_flits_gp - 1));
        end else if (b_hs_s) begin
            bvalid_r    <= 1'b0;
        end
    end

    // output handoff bookkeeping
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_count_r <= 32'd0;
            done_r      <= 1'b0;
        end else if (out_hs_s) begin
            cmd_count_r <= cmd_count_r + 32'd1;
            done_r      <= done_r | (nbf_o.opcode == nbf_finish_opcode_gp);
        end
    end

    // read channel, one outstanding read at a time
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= cmd_count_r;
        end else if (rvalid_r && s_axil_rready) begin
            rvalid_r <= 1'b0;
        end
    end

    assign nbf_o         = {flit_r[4][nbf_opcode_width_gp-1:0], flit_r[3], flit_r[2], flit_r[1], flit_r[0]};
    assign nbf_v_o       = (state_r == e_out);
    assign done_o        = done_r;
    assign s_axil_bvalid = bvalid_r;
    assign s_axil_bresp  = bresp_r;
    assign s_axil_rvalid = rvalid_r;
    assign s_axil_rdata  = rdata_r;
    assign s_axil_rresp  = 2'b00;

    assign unused_s = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb, s_axil_araddr,
                        flit_r[4][nbf_flit_width_gp-1:nbf_opcode_width_gp]};

endmodule

// File: tb/tb_bp_axil_nbf_deserializer.sv
// Directed and randomized bench for bp_axil_nbf_deserializer against a
// queue-based model of the five-flit command assembly.
module tb_bp_axil_nbf_deserializer;
    import bp_nbf_pkg::*;

    localparam logic [63:0] host_addr = 64'h0;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] s_axil_awaddr, s_axil_araddr;
    logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic [2:0]  s_axil_awprot, s_axil_arprot;
    logic [31:0] s_axil_wdata, s_axil_rdata;
    logic [3:0]  s_axil_wstrb;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic        s_axil_rvalid, s_axil_rready;
    bp_nbf_s     nbf_o;
    logic        nbf_v_o, nbf_ready_and_i, done_o;

    bp_axil_nbf_deserializer #(
        .S_AXIL_ADDR_WIDTH(64),
        .S_AXIL_DATA_WIDTH(32),
        .nbf_host_addr_p  (host_addr)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready), .s_axil_awprot(s_axil_awprot),
        .s_axil_wdata(s_axil_wdata), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_arprot(s_axil_arprot),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .nbf_o(nbf_o), .nbf_v_o(nbf_v_o), .nbf_ready_and_i(nbf_ready_and_i),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_q[$];
    int          model_count = 0;
    bit          model_done = 1'b0;
    bp_nbf_s     last_nbf;

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit sig_sel(input int which);
        case (which)
            0:       return s_axil_awready;
            1:       return s_axil_wready;
            2:       return s_axil_awready & s_axil_wready;
            default: return s_axil_arready;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int t = 0;
        while (!sig_sel(which) && t < 64) begin
            tick();
            t++;
        end
        check(tag, 136'(sig_sel(which)), 136'(1'b1));
    endtask

    // Expected command straight from the flit layout: data, then addr, then opcode.
    function automatic bp_nbf_s model_cmd();
        bp_nbf_s c;
        c.data   = {model_q[1], model_q[0]};
        c.addr   = {model_q[3], model_q[2]};
        c.opcode = model_q[4][7:0];
        return c;
    endfunction

    task automatic do_write(input logic [63:0] addr, input logic [31:0] data, input int wlead);
        logic [1:0] exp_resp;
        if (wlead > 0) begin
            s_axil_wdata = data; s_axil_wvalid = 1'b1;
            wait_for(1, "wready");
            tick();
            s_axil_wvalid = 1'b0;
            repeat (wlead - 1) tick();
            check("wready_while_held", 136'(s_axil_wready), 136'(1'b0));
            s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
            wait_for(0, "awready");
            tick();
            s_axil_awvalid = 1'b0;
        end else begin
            s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
            s_axil_wdata = data; s_axil_wvalid = 1'b1;
            wait_for(2, "aw_w_ready");
            tick();
            s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        end
        exp_resp = (addr == host_addr) ? 2'b00 : 2'b10;
        if (addr == host_addr) model_q.push_back(data);
        check("bvalid", 136'(s_axil_bvalid), 136'(1'b1));
        check("bresp", 136'(s_axil_bresp), 136'(exp_resp));
        tick();
        check("bvalid_drop", 136'(s_axil_bvalid), 136'(1'b0));
        check("nbf_v_after_b", 136'(nbf_v_o), 136'(model_q.size() == 5));
    endtask

    task automatic take_output(input int delay);
        bp_nbf_s exp_cmd;
        exp_cmd = model_cmd();
        model_q.delete();
        last_nbf = nbf_o;
        check("nbf_v", 136'(nbf_v_o), 136'(1'b1));
        check("nbf_o", 136'(nbf_o), 136'(exp_cmd));
        repeat (delay) begin
            nbf_ready_and_i = 1'b0;
            tick();
            check("stall_ready", 136'({s_axil_awready, s_axil_wready}), 136'(2'b00));
            check("stall_nbf_o", 136'(nbf_o), 136'(exp_cmd));
            check("stall_nbf_v", 136'(nbf_v_o), 136'(1'b1));
        end
        nbf_ready_and_i = 1'b1;
        tick();
        nbf_ready_and_i = 1'b0;
        model_count++;
        if (exp_cmd.opcode == 8'hFF) model_done = 1'b1;
        check("nbf_v_drop", 136'(nbf_v_o), 136'(1'b0));
        check("done", 136'(done_o), 136'(model_done));
    endtask

    task automatic send_cmd(input logic [31:0] f [5], input int wlead, input int delay, input int bad_pos);
        for (int i = 0; i < 5; i++) begin
            if (i == bad_pos) do_write(host_addr + 64'd4, $urandom, wlead);
            do_write(host_addr, f[i], wlead);
        end
        take_output(delay);
    endtask

    task automatic do_read;
        s_axil_araddr = {$urandom, $urandom};
        s_axil_arvalid = 1'b1;
        wait_for(3, "arready");
        tick();
        s_axil_arvalid = 1'b0;
        check("rvalid", 136'(s_axil_rvalid), 136'(1'b1));
        check("rdata", 136'(s_axil_rdata), 136'(32'(model_count)));
        check("rresp", 136'(s_axil_rresp), 136'(2'b00));
        s_axil_rready = 1'b1;
        tick();
        s_axil_rready = 1'b0;
        check("rvalid_drop", 136'(s_axil_rvalid), 136'(1'b0));
    endtask

    task automatic check_reset_values(input string tag);
        check(tag, 136'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid,
                         s_axil_rvalid, nbf_v_o, done_o, s_axil_bresp, s_axil_rresp, s_axil_rdata}),
              136'(0));
    endtask

    initial begin
        logic [31:0] f [5];
        bp_nbf_s     exp1;

        reset_i = 1'b1;
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_awprot = 3'd0;
        s_axil_wdata = '0; s_axil_wvalid = 1'b0; s_axil_wstrb = 4'hF;
        s_axil_bready = 1'b1; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
        s_axil_arprot = 3'd0; s_axil_rready = 1'b0; nbf_ready_and_i = 1'b0;
        tick(); tick();
        check_reset_values("reset_values");
        reset_i = 1'b0;
        tick();

        // 1: simultaneous AW/W
        f = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h10};
        send_cmd(f, 0, 0, 9);
        exp1.opcode = 8'h10;
        exp1.addr   = 64'h00000004_00000003;
        exp1.data   = 64'h00000002_00000001;
        check("scn1_literal", 136'(last_nbf), 136'(exp1));

        // 2: W three cycles ahead of AW
        send_cmd(f, 3, 0, 9);
        check("scn2_literal", 136'(last_nbf), 136'(exp1));

        // 3: stray address mid-command
        send_cmd(f, 0, 0, 2);

        // 4: consumer stalls for 10 cycles
        f = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FF21};
        send_cmd(f, 1, 10, 9);

        // 5: finish command, then read the count
        f = '{32'h11, 32'h22, 32'h33, 32'h44, 32'hFF};
        send_cmd(f, 0, 2, 9);
        check("done_set", 136'(done_o), 136'(1'b1));
        do_read();

        // 6: reset after three flits
        f = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'h0, 32'h0};
        for (int i = 0; i < 3; i++) do_write(host_addr, f[i], 0);
        reset_i = 1'b1;
        #1;
        check_reset_values("mid_reset_values");
        tick();
        reset_i = 1'b0;
        model_q.delete();
        model_count = 0;
        model_done = 1'b0;
        tick();
        check("done_after_reset", 136'(done_o), 136'(1'b0));
        f = '{32'hBEEF_0000, 32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003, 32'h0000_0042};
        send_cmd(f, 0, 0, 9);
        do_read();

        // randomized commands
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 5; i++) f[i] = $urandom;
            if ($urandom_range(0, 3) == 0) f[4][7:0] = 8'hFF;
            send_cmd(f, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6));
            if (c % 4 == 3) do_read();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/bp_axil_nbf_deserializer.md
BP_AXIL_NBF_DESERIALIZER -- requirements
Module: bp_axil_nbf_deserializer

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- S_AXIL_ADDR_WIDTH, 64, AXI-Lite address width.
- S_AXIL_DATA_WIDTH, 32, AXI-Lite data width; only 32 is legal.
- nbf_host_addr_p, 64'h0, the single write address accepted as the NBF port.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning), clock and reset first:
- clk_i, in, 1, sole clock.
- reset_i, in, 1, asynchronous, active-high reset.
- s_axil_awaddr/awvalid/awready/awprot, in/in/out/in, ADDR/1/1/3, write-address channel.
- s_axil_wdata/wvalid/wready/wstrb, in/in/out/in, 32/1/1/4, write-data channel.
- s_axil_bresp/bvalid/bready, out/out/in, 2/1/1, write-response channel.
- s_axil_araddr/arvalid/arready/arprot, in/in/out/in, ADDR/1/1/3, read-address channel.
- s_axil_rdata/rresp/rvalid/rready, out/out/out/in, 32/2/1/1, read-data channel.
- nbf_o, out, 136, assembled command as packed {opcode[7:0], addr[63:0], data[63:0]}.
- nbf_v_o, out, 1, nbf_o is valid.
- nbf_ready_and_i, in, 1, consumer accepts nbf_o.
- done_o, out, 1, sticky flag: a finish command (opcode 8'hFF) has been handed off.

Function
REQ-003 Each NBF command SHALL arrive as 5 consecutive 32-bit flits: flit0=data[31:0], flit1=data[63:32], flit2=addr[31:0], flit3=addr[63:32], flit4=opcode in bits [7:0] (bits [31:8] ignored).
REQ-004 AW and W SHALL be captured independently in one-entry holding registers; awready equals ~aw_held, and wready equals ~w_held; both are 0 outside state e_recv.
REQ-005 A write SHALL commit in the cycle both AW and W are available, whether held or handshaking in that cycle; AW and W on the same cycle SHALL commit that same cycle.
REQ-006 A committed write with awaddr==nbf_host_addr_p SHALL store wdata at flit index flit_cnt and increment flit_cnt; wstrb is ignored.
REQ-007 A committed write with any other address SHALL be discarded without changing flit_cnt, and answered with bresp=2'b10 (SLVERR).
REQ-008 A matching write SHALL be answered with bresp=2'b00.
REQ-009 bvalid SHALL assert the cycle after commit and hold until bready is high.
REQ-010 The FSM SHALL have states e_recv, e_resp and e_out:
- e_recv -> e_resp on commit.
- e_resp -> e_out on the B handshake when the committed flit was flit4 (matching address); flit_cnt clears to 0.
- e_resp -> e_recv on the B handshake otherwise.
- e_out -> e_recv when nbf_v_o and nbf_ready_and_i are both high.
REQ-011 nbf_v_o SHALL be high only in e_out, with nbf_o stable until the handshake, so latency from the flit4 B handshake to nbf_v_o is 1 cycle.
REQ-012 During e_resp and e_out no new AW/W SHALL be accepted; this is the sole backpressure mechanism.
REQ-013 On an output handshake with opcode==8'hFF, done_o SHALL set the next cycle and stay set until reset; later commands are still processed.
REQ-014 cmd_count (32-bit, wraps 2^32-1 -> 0) SHALL increment on every output handshake.
REQ-015 Reads SHALL be served one at a time:
- arready=~rvalid.
- rvalid asserts 1 cycle after the AR handshake and holds until rready.
- rdata=cmd_count, rresp=2'b00, address ignored.
- Reads SHALL be independent of the write FSM.

Reset
REQ-016 While reset_i is high, the block SHALL drive these values:
- State: e_recv.
- Counters: flit_cnt=0, cmd_count=0.
- Holding registers: aw/w cleared.
- Outputs: bvalid=0, rvalid=0, nbf_v_o=0, done_o=0, bresp=0, rresp=0, rdata=0.
- awready/wready/arready=0.
REQ-017 A reset asserted mid-command SHALL discard all partial flits, with no output emitted for them.

Structure
REQ-018 Package bp_nbf_pkg SHALL hold bp_nbf_s, the opcode/addr/data widths (8/64/64), the flit count of 5, and the finish opcode 8'hFF, shared with the NBF loader.
REQ-019 The flit counter SHALL be one bsg_counter_clear_up instance (max_val_p=5); all other logic SHALL be inline.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Five matching writes, flits 0x1,0x2,0x3,0x4,0x10 with AW/W simultaneous and bready=1 -> five OKAY responses; nbf_o={8'h10,64'h00000004_00000003,64'h00000002_00000001}, nbf_v_o one cycle after the fifth B handshake.
- The same command with W issued 3 cycles before AW on each flit -> identical nbf_o; wready low while W is held.
- Write to nbf_host_addr_p+4 mid-command -> SLVERR, flit_cnt unchanged; the command completes correctly with 5 matching writes.
- nbf_ready_and_i held low for 10 cycles after assembly -> awready/wready stay 0, nbf_o stable; handoff on the first ready cycle.
- Finish command (flit4=0xFF) handed off -> done_o=1 the next cycle; a subsequent read returns the command count (e.g. 2) with OKAY.
- reset_i pulsed after 3 flits, then 5 new flits -> exactly one command is output, built from the new flits only.
